// File: rtl/dcd_scan_ctrl_pkg.sv
// Shared state-list definitions for the decision scan controller.
//  - 2-bit value encodings of a variable entry
//  - bit offsets inside one WIDTH-bit entry: [2:1] value, [0] implied flag
//  - FSM state encodings for dcd_scan_ctrl
//  - helper that builds one entry from a value and an implied flag
package dcd_scan_ctrl_pkg;

  localparam logic [1:0] VAL_FREE  = 2'b00;
  localparam logic [1:0] VAL_FALSE = 2'b01;
  localparam logic [1:0] VAL_TRUE  = 2'b10;

  localparam int VAL_LSB = 1;
  localparam int VAL_MSB = 2;
  localparam int IMP_BIT = 0;
  localparam int ENT_W   = VAL_MSB + 1;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t SCAN = 2'd1;
  localparam state_t DONE = 2'd2;

  function automatic logic [ENT_W-1:0] mk_entry(input logic [1:0] val, input logic imp);
    logic [ENT_W-1:0] e;
    e                  = '0;
    e[VAL_MSB:VAL_LSB] = val;
    e[IMP_BIT]         = imp;
    return e;
  endfunction

endpackage

// File: rtl/dcd_seg_pick.sv
// Combinational free-variable picker for one scan segment.
//  val_i  in  SEG*WIDTH  value slice of SEG consecutive variables
//  vld_i  in  SEG        1 = slot holds a real variable (padding slots are 0)
//  hit_o  out 1          some valid slot is free
//  idx_o  out LIDX_W     lowest free slot index inside the segment
module dcd_seg_pick
  import dcd_scan_ctrl_pkg::*;
#(
  parameter int SEG    = 4,
  parameter int WIDTH  = 3,
  parameter int LIDX_W = (SEG > 1) ? $clog2(SEG) : 1
) (
  input  logic [SEG*WIDTH-1:0] val_i,
  input  logic [SEG-1:0]       vld_i,
  output logic                 hit_o,
  output logic [LIDX_W-1:0]    idx_o
);

  logic [SEG-1:0] free;
  logic [SEG-1:0] unused_imp;

  for (genvar j = 0; j < SEG; j++) begin : g_lane
    assign free[j]       = vld_i[j] && (val_i[j*WIDTH+VAL_LSB +: 2] == VAL_FREE);
    // implied flag does not affect freeness
    assign unused_imp[j] = val_i[j*WIDTH+IMP_BIT];
  end

  // descending walk so the lowest free slot wins
  always_comb begin
    hit_o = |free;
    idx_o = '0;
    for (int j = SEG - 1; j >= 0; j--) begin
      if (free[j]) idx_o = LIDX_W'(j);
    end
  end

endmodule

// File: rtl/dcd_scan_ctrl.sv
// Sequential decision controller: on start_i scans the packed variable state
// bus one SEG-wide segment per cycle, picks the first free variable and emits
// a decision write (index, value FALSE, level_i+1), or reports all assigned.
// Optional macro DCD_ROUND_ROBIN_EN: scan begins at the segment after the one
// holding the last decided variable instead of segment 0.
//  clk, rst      clock, synchronous active-high reset
//  start_i       request a decision (accepted only in IDLE)
//  value_i       packed variable states, stable while busy_o
//  level_i       current decision level
//  busy_o        high in SCAN and DONE
//  done_o        one-cycle completion pulse
//  found_o       1 = decided, 0 = all assigned (or overflow)
//  var_idx_o     decided variable index
//  wr_value_o    entry to write (FALSE, not implied)
//  wr_level_o    level_i+1
//  ovf_o         level_i was all-ones; no decision
module dcd_scan_ctrl
  import dcd_scan_ctrl_pkg::*;
#(
  parameter int NUM_VARS = 8,
  parameter int WIDTH    = 3,
  parameter int SEG      = 4,
  parameter int LVL_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [NUM_VARS*WIDTH-1:0] value_i,
  input  logic [LVL_W-1:0]          level_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      found_o,
  output logic [$clog2(NUM_VARS)-1:0] var_idx_o,
  output logic [WIDTH-1:0]          wr_value_o,
  output logic [LVL_W-1:0]          wr_level_o,
  output logic                      ovf_o
);

  localparam int IDX_W  = $clog2(NUM_VARS);
  localparam int NSEG   = (NUM_VARS + SEG - 1) / SEG;
  localparam int SEG_W  = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int LEFT_W = $clog2(NSEG + 1);
  localparam int LIDX_W = (SEG > 1) ? $clog2(SEG) : 1;
  localparam logic [WIDTH-1:0] WR_FALSE = WIDTH'(mk_entry(VAL_FALSE, 1'b0));

  state_t              state_q, state_d;
  logic [SEG_W-1:0]    seg_cnt_q, seg_cnt_d;
  logic [LEFT_W-1:0]   seg_left_q, seg_left_d;
  logic                found_q, found_d;
  logic                ovf_q, ovf_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0]    wr_value_q, wr_value_d;
  logic [LVL_W-1:0]    wr_level_q, wr_level_d;
  logic [SEG_W-1:0]    start_seg;
`ifdef DCD_ROUND_ROBIN_EN
  logic [SEG_W-1:0]    last_seg_q, last_seg_d;
  logic                last_vld_q, last_vld_d;
`endif

  // Segment table: padding slots past NUM_VARS read as invalid zeros
  logic [NSEG-1:0][SEG*WIDTH-1:0] seg_val;
  logic [NSEG-1:0][SEG-1:0]       seg_vld;

  for (genvar s = 0; s < NSEG; s++) begin : g_seg
    for (genvar j = 0; j < SEG; j++) begin : g_slot
      if (s * SEG + j < NUM_VARS) begin : g_real
        assign seg_val[s][j*WIDTH +: WIDTH] = value_i[(s*SEG+j)*WIDTH +: WIDTH];
        assign seg_vld[s][j]                = 1'b1;
      end else begin : g_pad
        assign seg_val[s][j*WIDTH +: WIDTH] = '0;
        assign seg_vld[s][j]                = 1'b0;
      end
    end
  end

  logic              hit;
  logic [LIDX_W-1:0] loc_idx;
  logic [IDX_W-1:0]  hit_idx;

  dcd_seg_pick #(.SEG(SEG), .WIDTH(WIDTH), .LIDX_W(LIDX_W)) u_pick (
    .val_i (seg_val[seg_cnt_q]),
    .vld_i (seg_vld[seg_cnt_q]),
    .hit_o (hit),
    .idx_o (loc_idx)
  );

  assign hit_idx = IDX_W'(int'(seg_cnt_q) * SEG + int'(loc_idx));

  function automatic logic [SEG_W-1:0] next_seg(input logic [SEG_W-1:0] s);
    return (s == SEG_W'(NSEG - 1)) ? '0 : s + SEG_W'(1);
  endfunction

`ifdef DCD_ROUND_ROBIN_EN
  // before the first decision there is no last segment; start at 0
  assign start_seg = last_vld_q ? next_seg(last_seg_q) : '0;
`else
  assign start_seg = '0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      seg_cnt_q  <= '0;
      seg_left_q <= '0;
      found_q    <= 1'b0;
      ovf_q      <= 1'b0;
      idx_q      <= '0;
      wr_value_q <= '0;
      wr_level_q <= '0;
`ifdef DCD_ROUND_ROBIN_EN
      last_seg_q <= '0;
      last_vld_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      seg_cnt_q  <= seg_cnt_d;
      seg_left_q <= seg_left_d;
      found_q    <= found_d;
      ovf_q      <= ovf_d;
      idx_q      <= idx_d;
      wr_value_q <= wr_value_d;
      wr_level_q <= wr_level_d;
`ifdef DCD_ROUND_ROBIN_EN
      last_seg_q <= last_seg_d;
      last_vld_q <= last_vld_d;
`endif
    end
  end

  // Next state and datapath
  always_comb begin
    state_d    = state_q;
    seg_cnt_d  = seg_cnt_q;
    seg_left_d = seg_left_q;
    found_d    = found_q;
    ovf_d      = ovf_q;
    idx_d      = idx_q;
    wr_value_d = wr_value_q;
    wr_level_d = wr_level_q;
`ifdef DCD_ROUND_ROBIN_EN
    last_seg_d = last_seg_q;
    last_vld_d = last_vld_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          found_d    = 1'b0;
          ovf_d      = 1'b0;
          idx_d      = '0;
          wr_value_d = '0;
          if (&level_i) begin
            // next level would wrap; refuse to decide
            ovf_d      = 1'b1;
            wr_level_d = '0;
            state_d    = DONE;
          end else begin
            wr_level_d = level_i + LVL_W'(1);
            seg_cnt_d  = start_seg;
            seg_left_d = LEFT_W'(NSEG);
            state_d    = SCAN;
          end
        end
      end
      SCAN: begin
        if (hit) begin
          found_d    = 1'b1;
          idx_d      = hit_idx;
          wr_value_d = WR_FALSE;
          state_d    = DONE;
`ifdef DCD_ROUND_ROBIN_EN
          last_seg_d = seg_cnt_q;
          last_vld_d = 1'b1;
`endif
        end else begin
          seg_cnt_d  = next_seg(seg_cnt_q);
          seg_left_d = seg_left_q - LEFT_W'(1);
          if (seg_left_q == LEFT_W'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o     = (state_q != IDLE);
    done_o     = (state_q == DONE);
    found_o    = found_q;
    ovf_o      = ovf_q;
    var_idx_o  = idx_q;
    wr_value_o = wr_value_q;
    wr_level_o = wr_level_q;
  end

endmodule

// File: tb/tb_dcd_scan_ctrl.sv
module tb_dcd_scan_ctrl;
  localparam int NV = 8, W = 3, SG = 4, LW = 8, NSEG = 2;

  logic          clk = 1'b0;
  logic          rst, start_i;
  logic [NV*W-1:0] value_i;
  logic [LW-1:0] level_i;
  logic          busy_o, done_o, found_o, ovf_o;
  logic [2:0]    var_idx_o;
  logic [W-1:0]  wr_value_o;
  logic [LW-1:0] wr_level_o;

  int checks = 0;
  int failures = 0;
  int m_have = 0;
  int m_last = 0;

  dcd_scan_ctrl #(.NUM_VARS(NV), .WIDTH(W), .SEG(SG), .LVL_W(LW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .value_i(value_i), .level_i(level_i),
    .busy_o(busy_o), .done_o(done_o), .found_o(found_o), .var_idx_o(var_idx_o),
    .wr_value_o(wr_value_o), .wr_level_o(wr_level_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // f[2v+:2] is the value field of variable v; implied bits random
  function automatic logic [NV*W-1:0] pack(input logic [2*NV-1:0] f);
    logic [NV*W-1:0] r;
    for (int v = 0; v < NV; v++) r[v*W +: W] = {f[2*v +: 2], 1'($urandom_range(0, 1))};
    return r;
  endfunction

  // Reference: walk segments in visiting order, first free variable wins
  task automatic model(input logic [NV*W-1:0] v, input logic [LW-1:0] l,
                       output int lat, output int fnd, output int idx, output int ovf);
    int s0;
    lat = NSEG + 1; fnd = 0; idx = 0; ovf = 0; s0 = 0;
    if (l == 8'hFF) begin
      lat = 1; ovf = 1;
    end else begin
`ifdef DCD_ROUND_ROBIN_EN
      if (m_have != 0) s0 = (m_last + 1) % NSEG;
`endif
      for (int k = 0; k < NSEG && fnd == 0; k++) begin
        int s;
        s = (s0 + k) % NSEG;
        for (int j = 0; j < SG && fnd == 0; j++) begin
          int vi;
          vi = s * SG + j;
          if (vi < NV && v[vi*W+1 +: 2] == 2'b00) begin
            fnd = 1; idx = vi; lat = k + 2; m_have = 1; m_last = s;
          end
        end
      end
    end
  endtask

  task automatic run_req(input logic [NV*W-1:0] v, input logic [LW-1:0] l, input bit pulse);
    int lat, fnd, idx, ovf, cyc;
    bit got;
    model(v, l, lat, fnd, idx, ovf);
    @(negedge clk);
    value_i = v; level_i = l; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; cyc = 1; got = 1'b0;
    chk("busy_c1", 32'(busy_o), 32'd1);
    while (!got && cyc <= NSEG + 3) begin
      if (done_o) begin
        got = 1'b1;
        start_i = 1'b0;
      end else begin
        start_i = pulse;
        @(negedge clk);
        cyc++;
      end
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    else begin
      chk("latency", 32'(cyc), 32'(lat));
      chk("found", 32'(found_o), 32'(fnd));
      chk("ovf", 32'(ovf_o), 32'(ovf));
      if (fnd != 0) begin
        chk("var_idx", 32'(var_idx_o), 32'(idx));
        chk("wr_value", 32'(wr_value_o), 32'h2);
      end
      if (ovf == 0) chk("wr_level", 32'(wr_level_o), 32'(8'(l + 8'd1)));
    end
    @(negedge clk);
    chk("done_after", 32'(done_o), 32'd0);
    chk("busy_after", 32'(busy_o), 32'd0);
    chk("found_hold", 32'(found_o), 32'(fnd));
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    logic [2*NV-1:0] f;
    rst = 1'b1; start_i = 1'b0; value_i = '0; level_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_found", 32'(found_o), 32'd0);
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    chk("rst_idx", 32'(var_idx_o), 32'd0);
    chk("rst_wrval", 32'(wr_value_o), 32'd0);
    chk("rst_wrlvl", 32'(wr_level_o), 32'd0);

    // directed: all free, first free at var 6, all assigned, level overflow
    run_req(pack(16'h0000), 8'd3, 1'b0);
    run_req(pack({2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01}), 8'd10, 1'b0);
    run_req(pack({8{2'b01}}), 8'd5, 1'b0);
    run_req(pack({8{2'b10}}), 8'd0, 1'b0);
    run_req(pack(16'h0000), 8'hFF, 1'b0);

    // reset in the middle of a scan discards it
    @(negedge clk);
    value_i = pack(16'h5505); level_i = 8'd7; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; m_have = 0; m_last = 0;
    chk("rstmid_busy", 32'(busy_o), 32'd0);
    chk("rstmid_found", 32'(found_o), 32'd0);
    chk("rstmid_wrlvl", 32'(wr_level_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_nodone", 32'(done_o), 32'd0);
      @(negedge clk);
    end
    run_req(pack(16'h0000), 8'd3, 1'b0);

    // all free three times with ignored start pulses while busy
    for (int i = 0; i < 3; i++) run_req(pack(16'h0000), 8'(i + 1), 1'b1);

    // randomized requests
    for (int n = 0; n < 60; n++) begin
      for (int v = 0; v < NV; v++)
        f[2*v +: 2] = ($urandom_range(0, 9) < 2) ? 2'b00 : (($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10);
      run_req(pack(f), ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 254)),
              1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
